dfp_line_mem_responder: RTL

- Parametrised downstream backing-memory responder for the cache verification environment; sits on the DFP side of the cache under test.
- Accepts line-granular read and write requests.
- Returns responses after a configurable latency, extendable by a stall input.
- Detects DFP protocol violations and counts completed transactions.
- Synthesisable, so the same model serves simulation benches and the FPGA bring-up harness.

---
 rtl/dfp_line_mem_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dfp_line_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dfp_line_mem_responder : line-granular DFP backing memory with latency,
// stall, protocol-error detection and completion counters.   rev 1.0
// ----------------------------------------------------------------------------
module dfp_line_mem_responder #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] dfp_addr,
   input  logic              dfp_read,
   input  logic              dfp_write,
   input  logic [LINE_W-1:0] dfp_wdata,
   output logic [LINE_W-1:0] dfp_rdata,
   output logic              dfp_resp,
   input  logic              stall,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int REP   = LINE_W / 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] ERR_BOTH  = 2'd0;
   localparam logic [1:0] ERR_ALIGN = 2'd1;
   localparam logic [1:0] ERR_CHG   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              read_q;
   logic              write_q;
   logic [LINE_W-1:0] wdata_q;
   logic [DEPTH-1:0]  valid_q;
   logic              resp_q;
   logic [LINE_W-1:0] rdata_q;
   logic              err_q;
   logic [1:0]        err_code_q;
   logic [CNT_W-1:0]  rd_cnt_q;
   logic [CNT_W-1:0]  wr_cnt_q;

   logic [LINE_W-1:0] mem [DEPTH];

   logic              w_accept;
   logic              w_to_resp;
   logic              w_err_set;
   logic [1:0]        w_err_code;
   logic              w_mismatch;

   logic [ADDR_W-1:0] w_c_addr;
   logic              w_c_write;
   logic [LINE_W-1:0] w_c_wdata;
   logic [ADDR_W-1:0] w_c_line;
   logic [IDX_W-1:0]  w_c_idx;
   logic [31:0]       w_pat_word;
   logic [LINE_W-1:0] w_rd_line;

   assign w_mismatch = (dfp_addr  != addr_q)  ||
                       (dfp_read  != read_q)  ||
                       (dfp_write != write_q) ||
                       (dfp_wdata != wdata_q) ||
                       (!dfp_read && !dfp_write);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      w_accept   = 1'b0;
      w_to_resp  = 1'b0;
      w_err_set  = 1'b0;
      w_err_code = ERR_BOTH;
      case (state_q)
         IDLE: begin
            if (dfp_read && dfp_write) begin
               w_err_set  = 1'b1;
               w_err_code = ERR_BOTH;
            end else if (dfp_read || dfp_write) begin
               w_accept = 1'b1;
               cnt_d    = LAT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d   = RESP;
                  w_to_resp = 1'b1;
               end else begin
                  state_d = BUSY;
               end
               if (|dfp_addr[OFF_W-1:0]) begin
                  w_err_set  = 1'b1;
                  w_err_code = ERR_ALIGN;
               end
            end
         end
         BUSY: begin
            if (w_mismatch) begin
               w_err_set  = 1'b1;
               w_err_code = ERR_CHG;
            end
            if (!stall) begin
               if (cnt_q == '0) begin
                  state_d   = RESP;
                  w_to_resp = 1'b1;
               end else begin
                  cnt_d = cnt_q - LAT_W'(1);
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY = 1 the commit happens on the accepting edge, so the live
   // request is used instead of the latched copy.
   assign w_c_addr   = (state_q == IDLE) ? dfp_addr  : addr_q;
   assign w_c_write  = (state_q == IDLE) ? dfp_write : write_q;
   assign w_c_wdata  = (state_q == IDLE) ? dfp_wdata : wdata_q;
   assign w_c_line   = {w_c_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign w_c_idx    = w_c_addr[OFF_W+IDX_W-1:OFF_W];
   assign w_pat_word = 32'(w_c_line);
   assign w_rd_line  = valid_q[w_c_idx] ? mem[w_c_idx] : {REP{w_pat_word}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         valid_q    <= '0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_BOTH;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= w_to_resp;
         if (w_accept) begin
            addr_q  <= dfp_addr;
            read_q  <= dfp_read;
            write_q <= dfp_write;
            wdata_q <= dfp_wdata;
         end
         if (w_err_set && !err_q) begin
            err_q      <= 1'b1;
            err_code_q <= w_err_code;
         end
         if (w_to_resp) begin
            if (w_c_write) begin
               valid_q[w_c_idx] <= 1'b1;
               wr_cnt_q         <= wr_cnt_q + CNT_W'(1);
            end else begin
               rdata_q  <= w_rd_line;
               rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Storage carries no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (rst && w_to_resp && w_c_write) begin
         mem[w_c_idx] <= w_c_wdata;
      end
   end

   assign dfp_rdata = rdata_q;
   assign dfp_resp  = resp_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;

endmodule
`default_nettype wire
